expression_level_one_counter: RTL and testbench
===============================================

Name: expression_level_one_counter

Overview:
- Counts how many of the three 1-bit inputs a, b, c are high (0..3) and presents the result as a 2-bit binary code y1:y0.
- The count is built from gate-level Boolean expressions: no adders, no case tables.
- Alongside the combinational count, the block provides a registered copy, a change strobe and a saturating running total.
- Used as a small popcount/majority primitive and as a gate-level reference block.

Parameters:
- ACC_W, 8, width of the running-total accumulator (min 2).

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  1  data bit 0.
- b  input  1  data bit 1.
- c  input  1  data bit 2.
- en  input  1  accumulate enable for the running total.
- clr  input  1  synchronous clear of the running total.
- y0  output  1  count LSB, combinational.
- y1  output  1  count MSB, combinational.
- cnt_q  output  2  registered {y1,y0}.
- changed  output  1  one-cycle pulse when cnt_q changes value.
- total  output  ACC_W  saturating sum of counts.
- total_sat  output  1  high when total equals its maximum, 2^ACC_W-1.

Behaviour:
- Combinational path (no clock dependence, zero latency):
  - y0 = a XOR b XOR c.
  - y1 = (a AND b) OR (b AND c) OR (a AND c), i.e. the majority function.
  - Full truth table for abc -> y1y0: 000->00, 001->01, 010->01, 100->01, 011->10, 101->10, 110->10, 111->11.
  - y0/y1 must follow input changes with no registers, so they stay valid while rst is asserted.
- Registered copy:
  - cnt_q <= {y1,y0} every rising edge.
  - Latency is 1 cycle from the input change.
- changed:
  - Registered.
  - Goes high for exactly 1 cycle on the edge where the new cnt_q differs from the previous cnt_q.
  - Stays low while the value is unchanged.
- Running total:
  - On each rising edge, priority order: clr=1 -> total <= 0; else if en=1 -> total <= min(total + {y1,y0}, 2^ACC_W-1); else hold.
  - The addition is zero-extended to ACC_W+1 bits before the saturation compare. total must never wrap.
  - clr and en asserted in the same cycle: clr wins, and the result is 0 (that cycle's count is not added).
- total_sat: combinational compare of total against all-ones.
- Reset (rst=1, asynchronous): cnt_q=00, changed=0, total=0, total_sat=0.
  - Reset asserted mid-accumulation clears total immediately, without waiting for a clock edge.
  - On the first edge after reset release, changed fires only if the count is nonzero, because the previous cnt_q was 00.
- X handling: none required. Inputs are assumed driven.

Test Plan:
- a=0,b=1,c=0 for 200 ns, then b->0 -> y1y0=01 then 00 immediately; cnt_q follows one clock later, and changed pulses once on that edge.
- a=0,b=1,c=1, then c->0 -> y1y0=10 then 01. a=1,b=0,c=0, then b->1 -> 01 then 10. a=1,b=1,c=0, then a->0 -> 10 then 01.
- Sweep all 8 abc codes -> y1y0 matches the truth table above; 111 -> 11.
- ACC_W=4, en=1, abc=111 held -> total goes 3, 6, 9, 12, 15, then stays at 15 with total_sat=1; total never wraps to a small value.
- clr=1 and en=1 together while total=9 -> total=0 on the next edge. en=0 -> total holds.
- Assert rst asynchronously between clock edges while total=7 -> total, cnt_q and changed go to 0 before the next edge. y0/y1 still reflect abc during reset.

Source files
------------

// File: rtl/expression_level_one_counter.sv
// Gate-level 3-input ones counter (popcount/majority) with a registered copy,
// a change strobe and a saturating running total of the counts.
module expression_level_one_counter #(
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             en,
    input  logic             clr,
    output logic             y0,
    output logic             y1,
    output logic [1:0]       cnt_q,
    output logic             changed,
    output logic [ACC_W-1:0] total,
    output logic             total_sat
);

    localparam logic [ACC_W-1:0] TOT_MAX = {ACC_W{1'b1}};

    logic [1:0]       cnt_d;
    logic             changed_q, changed_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic [ACC_W:0]   sum_wide;

    // Sum bit is the parity, carry bit is the majority: a full adder in gates.
    assign y0    = a ^ b ^ c;
    assign y1    = (a & b) | (b & c) | (a & c);
    assign cnt_d = {y1, y0};

    assign changed_d = (cnt_d != cnt_q);

    // One spare bit so the saturation compare sees the overflow instead of a wrap.
    assign sum_wide = {1'b0, total_q} + {{(ACC_W-1){1'b0}}, cnt_d};

    always_comb begin
        total_d = total_q;
        if (clr) begin
            total_d = '0;
        end else if (en) begin
            if (sum_wide > {1'b0, TOT_MAX}) total_d = TOT_MAX;
            else                            total_d = sum_wide[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 2'b00;
            changed_q <= 1'b0;
            total_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
            total_q   <= total_d;
        end
    end

    assign changed   = changed_q;
    assign total     = total_q;
    assign total_sat = (total_q == TOT_MAX);

endmodule

// File: tb/tb_expression_level_one_counter.sv
// Randomized + directed bench: an arithmetic reference model feeds a scoreboard
// queue each clock; a monitor pops and compares the registered outputs.
module tb_expression_level_one_counter;
    localparam int ACC_W = 4;
    localparam int MAXV  = (1 << ACC_W) - 1;

    logic clk = 1'b0, rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0, en = 1'b0, clr = 1'b0;
    logic y0, y1, changed, total_sat;
    logic [1:0]       cnt_q;
    logic [ACC_W-1:0] total;

    expression_level_one_counter #(.ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en), .clr(clr),
        .y0(y0), .y1(y1), .cnt_q(cnt_q), .changed(changed),
        .total(total), .total_sat(total_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int chg;
        int tot;
        int sat;
    } exp_t;

    exp_t sbq[$];
    int   m_cnt = 0, m_tot = 0;
    int   n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    endtask

    function automatic int ones(input logic x, input logic y, input logic z);
        return int'(x) + int'(y) + int'(z);
    endfunction

    // Reference model: count is plain arithmetic, total is min(sum, max).
    always @(posedge rst) begin
        m_cnt = 0;
        m_tot = 0;
    end

    always @(posedge clk) begin
        exp_t e;
        int   nc;
        if (rst) begin
            m_cnt = 0;
            m_tot = 0;
            e = '{0, 0, 0, 0};
        end else begin
            nc    = ones(a, b, c);
            e.chg = (nc != m_cnt) ? 1 : 0;
            m_cnt = nc;
            if (clr)     m_tot = 0;
            else if (en) m_tot = (m_tot + nc > MAXV) ? MAXV : m_tot + nc;
            e.cnt = m_cnt;
            e.tot = m_tot;
            e.sat = (m_tot == MAXV) ? 1 : 0;
        end
        sbq.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("cnt_q",     int'(cnt_q),     e.cnt);
            chk("changed",   int'(changed),   e.chg);
            chk("total",     int'(total),     e.tot);
            chk("total_sat", int'(total_sat), e.sat);
        end
    end

    task automatic setabc(input logic [2:0] v);
        {a, b, c} = v;
        #1;
        chk("y1y0", int'({y1, y0}), ones(v[2], v[1], v[0]));
    endtask

    logic [2:0] pairs [4][2];

    initial begin
        pairs[0][0] = 3'b010; pairs[0][1] = 3'b000;
        pairs[1][0] = 3'b011; pairs[1][1] = 3'b010;
        pairs[2][0] = 3'b100; pairs[2][1] = 3'b110;
        pairs[3][0] = 3'b110; pairs[3][1] = 3'b010;

        #2;
        chk("rst_cnt_q",     int'(cnt_q),     0);
        chk("rst_changed",   int'(changed),   0);
        chk("rst_total",     int'(total),     0);
        chk("rst_total_sat", int'(total_sat), 0);
        for (int i = 0; i < 8; i++) setabc(3'(i));

        @(negedge clk);
        rst = 1'b0;
        setabc(3'b000);
        @(negedge clk);

        for (int p = 0; p < 4; p++) begin
            setabc(pairs[p][0]);
            repeat ((p == 0) ? 20 : 3) @(negedge clk);
            setabc(pairs[p][1]);
            repeat (2) @(negedge clk);
        end

        for (int i = 0; i < 8; i++) begin
            setabc(3'(i));
            @(negedge clk);
        end

        // Saturation run: 3,6,9,12,15,15...
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; en = 1'b1;
        setabc(3'b111);
        repeat (8) @(negedge clk);
        chk("sat_total", int'(total), MAXV);
        chk("sat_flag",  int'(total_sat), 1);

        // clr wins over en
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("total_9", int'(total), 9);
        clr = 1'b1;
        @(negedge clk);
        chk("clr_en_total", int'(total), 0);
        clr = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_total", int'(total), 0);

        // Reach 7, then reset between edges
        en = 1'b1;
        repeat (2) @(negedge clk);
        setabc(3'b001);
        @(negedge clk);
        en = 1'b0;
        chk("total_7", int'(total), 7);
        #2 rst = 1'b1;
        #1;
        chk("arst_total",   int'(total),   0);
        chk("arst_cnt_q",   int'(cnt_q),   0);
        chk("arst_changed", int'(changed), 0);
        chk("arst_sat",     int'(total_sat), 0);
        chk("arst_y1y0",    int'({y1, y0}), 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            setabc(3'($urandom_range(0, 7)));
            en  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        en = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drain", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
